decoder_seq: RTL and testbench
==============================

Name: decoder_seq

Overview:
Parametrised, registered binary-to-one-hot decoder with a valid/ready input handshake. Each accepted code drives one output line, either as a timed strobe (pulse mode) or as a latched select (hold mode). Out-of-range codes are flagged. It replaces the combinational 2-to-4 decoder wherever timed or held select lines are needed, e.g. chip-select and LED/segment strobing on the FPGA board.

Parameters:
SEL_W, 2, select code width in bits; 1..8.
NUM_OUT, 4, number of one-hot outputs; 2..2**SEL_W.
MODE, 0, 0 = pulse mode, 1 = hold mode.
PULSE_LEN, 1, strobe length in clk cycles (pulse mode only); 1..255.

Ports:
clk  input  1  system clock, rising edge.
rst_n  input  1  synchronous active-low reset.
Din  input  SEL_W  select code.
Enable  input  1  code valid; a transfer occurs when Enable and Ready are both 1 at a rising edge.
Clear  input  1  drops the active output (aborts a pulse, or releases a held line).
Ready  output  1  block can accept a code this cycle.
Dout  output  NUM_OUT  registered one-hot output; all zero when idle.
Busy  output  1  1 while any Dout bit is 1.
Err  output  1  1-cycle pulse after an out-of-range code is accepted.

Behaviour:
- All state is clocked on the clk rising edge. Reset is synchronous and active-low.
- When rst_n is 0 at an edge: Dout=0, Err=0, FSM=IDLE, pulse counter=0. Ready=1 and Busy=0 follow from that state. Reset wins over every other input, including mid-pulse.
- FSM states: IDLE, ACTIVE. Busy = (state==ACTIVE).
- Accept means Enable & Ready at an edge. Latency is 1: Dout reflects the accepted code from the cycle after that edge.
- An in-range code (Din < NUM_OUT) sets Dout = 1<<Din, moves to ACTIVE and sets cnt=0.
- An out-of-range code (Din >= NUM_OUT) sets Dout=0 and Err=1 for exactly one cycle; the FSM goes to IDLE.
- Pulse mode (MODE=0):
  - In ACTIVE, cnt increments each cycle. On the edge where cnt==PULSE_LEN-1 with no accept, Dout goes to 0 and the FSM goes to IDLE. Each strobe is therefore exactly PULSE_LEN cycles.
  - Ready = IDLE | (ACTIVE & cnt==PULSE_LEN-1). This allows back-to-back strobes with zero gap.
  - An Enable arriving while Ready=0 is ignored; no queuing. The source must hold Enable until Ready.
- Hold mode (MODE=1):
  - Ready is always 1.
  - Dout holds the accepted line until Clear or a new accept. A new accept replaces the line with no intervening zero cycle.
  - The counter is unused.
- Clear applies in both modes: Clear=1 with no accept sends Dout to 0 and the FSM to IDLE at the next edge.
- Clear and accept in the same cycle: the accept wins and Clear is ignored.
- Accepting the same code that is already active:
  - pulse mode: restarts cnt;
  - hold mode: no visible change.
- Ready is combinational from state only. Dout, Err and Busy are registered or derived from state; there is no combinational path from Din or Enable to any output.

Optional Feature:
Macro DECODER_SEQ_ERRCNT_EN.
- Defined: adds output ErrCnt (8 bits). It resets to 0, increments on every out-of-range accept and saturates at 255. Clear does not affect it.
- Undefined: the port and its logic are absent. All other behaviour is identical.

Test Plan:
1. Reset, then pulse mode, SEL_W=2, NUM_OUT=4, PULSE_LEN=3; Din=2'b10, Enable=1 for one cycle -> Dout=4'b0100 for exactly 3 cycles starting 1 cycle after accept, then 4'b0000. Ready=0 for 2 cycles and Busy=1 for 3 cycles.
2. Same configuration, Enable held high with Din=0 then Din=3 presented when Ready -> Dout=0001 ×3 immediately followed by 1000 ×3, no zero gap. The Din=3 accept happens in the last 0001 cycle.
3. SEL_W=3, NUM_OUT=5, Din=3'd6 accepted -> Dout stays 0, Err=1 for one cycle, Ready stays 1. With DECODER_SEQ_ERRCNT_EN defined, ErrCnt 0->1; 300 bad codes -> ErrCnt=255.
4. Hold mode; accept Din=1 -> Dout=0010 held 10 cycles. Accept Din=3 -> 1000 next cycle. Clear=1 -> 0000 next cycle. Clear and Enable(Din=0) in the same cycle -> 0001.
5. Pulse mode, PULSE_LEN=5; rst_n=0 for one edge at cycle 2 of a strobe -> Dout=0, Busy=0, Ready=1 on the next cycle. Clear mid-strobe (no reset) -> Dout=0 next cycle.
6. Pulse mode; Enable=1 while Ready=0 with a different Din -> ignored, and the current strobe completes its full PULSE_LEN unchanged.

Source files
------------

// File: rtl/decoder_seq.sv
// decoder_seq: registered binary-to-one-hot decoder with valid/ready input, pulse or hold output.
// Define DECODER_SEQ_ERRCNT_EN to add the saturating 8-bit ErrCnt output.
module decoder_seq #(
    parameter int SEL_W     = 2,
    parameter int NUM_OUT   = 4,
    parameter int MODE      = 0,
    parameter int PULSE_LEN = 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [SEL_W-1:0]   Din,
    input  logic               Enable,
    input  logic               Clear,
    output logic               Ready,
    output logic [NUM_OUT-1:0] Dout,
    output logic               Busy,
`ifdef DECODER_SEQ_ERRCNT_EN
    output logic [7:0]         ErrCnt,
`endif
    output logic               Err
);
    typedef enum logic {IDLE, ACTIVE} state_t;
    state_t             state_q, state_d;
    logic [NUM_OUT-1:0] dout_q, dout_d;
    logic [7:0]         cnt_q, cnt_d;
    logic               err_q, err_d;
    logic               last, accept, in_range, pulsing;
    assign last     = cnt_q == 8'(PULSE_LEN - 1);
    assign pulsing  = MODE == 0 && state_q == ACTIVE;
    // Ready depends on state only; the last strobe cycle reopens for back-to-back codes.
    assign Ready    = MODE != 0 || state_q == IDLE || last;
    assign accept   = Enable && Ready;
    assign in_range = int'(Din) < NUM_OUT;
    always_comb begin
        state_d = state_q;
        dout_d  = dout_q;
        cnt_d   = cnt_q;
        err_d   = 1'b0;
        if (accept) begin
            state_d = in_range ? ACTIVE : IDLE;
            dout_d  = in_range ? NUM_OUT'(1) << Din : '0;
            err_d   = !in_range;
            cnt_d   = '0;
        end else if (Clear || (pulsing && last)) begin
            state_d = IDLE;
            dout_d  = '0;
            cnt_d   = '0;
        end else if (pulsing) begin
            cnt_d = cnt_q + 8'd1;
        end
    end
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            dout_q  <= '0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            dout_q  <= dout_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end
    assign Dout = dout_q;
    assign Err  = err_q;
    assign Busy = state_q == ACTIVE;
`ifdef DECODER_SEQ_ERRCNT_EN
    logic [7:0] errcnt_q, errcnt_d;
    assign errcnt_d = (accept && !in_range && errcnt_q != 8'hFF) ? errcnt_q + 8'd1 : errcnt_q;
    always_ff @(posedge clk) begin
        if (!rst_n) errcnt_q <= '0;
        else        errcnt_q <= errcnt_d;
    end
    assign ErrCnt = errcnt_q;
`endif
endmodule

// File: tb/tb_decoder_seq.sv
// tb_decoder_seq: three decoder_seq configurations (pulse 4/len3, pulse 5-of-8/len5, hold 4)
// driven by directed and random stimulus and compared against a countdown-based reference model.
module tb_decoder_seq;
    logic       clk = 1'b0;
    logic       rst_n;
    logic [2:0] en, clr, rdy, busy, err;
    logic [1:0] din0, din2;
    logic [2:0] din1;
    logic [3:0] dout0, dout2;
    logic [4:0] dout1;
`ifdef DECODER_SEQ_ERRCNT_EN
    logic [7:0] ec0, ec1, ec2;
`endif
    int total = 0, bad = 0;
    int mode_c[3] = '{0, 0, 1};
    int plen_c[3] = '{3, 5, 1};
    int nout_c[3] = '{4, 5, 4};
    int line_m[3] = '{-1, -1, -1};
    int rem_m[3]  = '{0, 0, 0};
    int ecnt_m[3] = '{0, 0, 0};
    int err_m[3]  = '{0, 0, 0};

    always #5 clk = ~clk;

    decoder_seq #(.SEL_W(2), .NUM_OUT(4), .MODE(0), .PULSE_LEN(3)) u0 (
        .clk(clk), .rst_n(rst_n), .Din(din0), .Enable(en[0]), .Clear(clr[0]),
        .Ready(rdy[0]), .Dout(dout0), .Busy(busy[0]),
`ifdef DECODER_SEQ_ERRCNT_EN
        .ErrCnt(ec0),
`endif
        .Err(err[0]));
    decoder_seq #(.SEL_W(3), .NUM_OUT(5), .MODE(0), .PULSE_LEN(5)) u1 (
        .clk(clk), .rst_n(rst_n), .Din(din1), .Enable(en[1]), .Clear(clr[1]),
        .Ready(rdy[1]), .Dout(dout1), .Busy(busy[1]),
`ifdef DECODER_SEQ_ERRCNT_EN
        .ErrCnt(ec1),
`endif
        .Err(err[1]));
    decoder_seq #(.SEL_W(2), .NUM_OUT(4), .MODE(1), .PULSE_LEN(1)) u2 (
        .clk(clk), .rst_n(rst_n), .Din(din2), .Enable(en[2]), .Clear(clr[2]),
        .Ready(rdy[2]), .Dout(dout2), .Busy(busy[2]),
`ifdef DECODER_SEQ_ERRCNT_EN
        .ErrCnt(ec2),
`endif
        .Err(err[2]));

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int get_din(input int i);
        return i == 0 ? int'(din0) : i == 1 ? int'(din1) : int'(din2);
    endfunction

    function automatic logic [31:0] get_dout(input int i);
        return i == 0 ? 32'(dout0) : i == 1 ? 32'(dout1) : 32'(dout2);
    endfunction

`ifdef DECODER_SEQ_ERRCNT_EN
    function automatic logic [31:0] get_ec(input int i);
        return i == 0 ? 32'(ec0) : i == 1 ? 32'(ec1) : 32'(ec2);
    endfunction
`endif

    // Model: a strobe is "line plus cycles remaining"; ready whenever idle or on its final cycle.
    function automatic bit ready_m(input int i);
        return mode_c[i] == 1 || line_m[i] < 0 || rem_m[i] == 1;
    endfunction

    task automatic model_step();
        for (int i = 0; i < 3; i++) begin
            bit acc;
            int d;
            acc = en[i] && ready_m(i);
            d = get_din(i);
            err_m[i] = 0;
            if (!rst_n) begin
                line_m[i] = -1; rem_m[i] = 0; ecnt_m[i] = 0;
            end else if (acc) begin
                if (d < nout_c[i]) begin
                    line_m[i] = d; rem_m[i] = plen_c[i];
                end else begin
                    line_m[i] = -1; rem_m[i] = 0; err_m[i] = 1;
                    ecnt_m[i] = ecnt_m[i] < 255 ? ecnt_m[i] + 1 : 255;
                end
            end else if (clr[i]) begin
                line_m[i] = -1; rem_m[i] = 0;
            end else if (mode_c[i] == 0 && line_m[i] >= 0) begin
                rem_m[i]--;
                if (rem_m[i] == 0) line_m[i] = -1;
            end
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        model_step();
        #1;
        for (int i = 0; i < 3; i++) begin
            check($sformatf("dout%0d", i), get_dout(i), line_m[i] >= 0 ? 32'(1) << line_m[i] : 32'(0));
            check($sformatf("busy%0d", i), 32'(busy[i]), 32'(line_m[i] >= 0));
            check($sformatf("ready%0d", i), 32'(rdy[i]), 32'(ready_m(i)));
            check($sformatf("err%0d", i), 32'(err[i]), 32'(err_m[i]));
`ifdef DECODER_SEQ_ERRCNT_EN
            check($sformatf("errcnt%0d", i), get_ec(i), 32'(ecnt_m[i]));
`endif
        end
    endtask

    initial begin
        rst_n = 1'b0; en = '0; clr = '0; din0 = '0; din1 = '0; din2 = '0;
        cyc(); cyc();
        rst_n = 1'b1;
        check("rst_dout0", 32'(dout0), 32'd0);
        check("rst_ready0", 32'(rdy[0]), 32'd1);
        // single strobe of length 3
        en[0] = 1'b1; din0 = 2'd2; cyc(); en[0] = 1'b0;
        check("p1_first", 32'(dout0), 32'h4);
        cyc(); cyc();
        check("p1_last", 32'(dout0), 32'h4);
        cyc();
        check("p1_end", 32'(dout0), 32'h0);
        // back-to-back strobes, second code taken on the last cycle of the first
        en[0] = 1'b1; din0 = 2'd0; cyc(); cyc(); cyc();
        din0 = 2'd3; cyc(); en[0] = 1'b0;
        check("p2_b2b", 32'(dout0), 32'h8);
        repeat (3) cyc();
        // out-of-range code
        en[1] = 1'b1; din1 = 3'd6; cyc(); en[1] = 1'b0;
        check("p3_err", 32'(err[1]), 32'd1);
        check("p3_dout", 32'(dout1), 32'd0);
        cyc();
        check("p3_err_gone", 32'(err[1]), 32'd0);
        // hold mode
        en[2] = 1'b1; din2 = 2'd1; cyc(); en[2] = 1'b0;
        repeat (10) cyc();
        check("p4_hold", 32'(dout2), 32'h2);
        en[2] = 1'b1; din2 = 2'd3; cyc(); en[2] = 1'b0;
        check("p4_replace", 32'(dout2), 32'h8);
        clr[2] = 1'b1; cyc();
        check("p4_clear", 32'(dout2), 32'h0);
        en[2] = 1'b1; din2 = 2'd0; cyc(); en[2] = 1'b0; clr[2] = 1'b0;
        check("p4_acc_wins", 32'(dout2), 32'h1);
        // reset and clear mid-strobe
        en[1] = 1'b1; din1 = 3'd1; cyc(); en[1] = 1'b0; cyc();
        rst_n = 1'b0; cyc(); rst_n = 1'b1;
        check("p5_rst_dout", 32'(dout1), 32'd0);
        check("p5_rst_ready", 32'(rdy[1]), 32'd1);
        en[1] = 1'b1; din1 = 3'd4; cyc(); en[1] = 1'b0; cyc();
        clr[1] = 1'b1; cyc(); clr[1] = 1'b0;
        check("p5_clear", 32'(dout1), 32'd0);
        // enable while not ready is dropped
        en[0] = 1'b1; din0 = 2'd1; cyc();
        din0 = 2'd2; cyc(); en[0] = 1'b0; cyc();
        check("p6_kept", 32'(dout0), 32'h2);
        cyc();
        check("p6_end", 32'(dout0), 32'h0);
        // random traffic
        repeat (3000) begin
            rst_n = $urandom_range(0, 99) != 0;
            en = 3'($urandom);
            clr[0] = $urandom_range(0, 7) == 0;
            clr[1] = $urandom_range(0, 7) == 0;
            clr[2] = $urandom_range(0, 7) == 0;
            din0 = 2'($urandom); din1 = 3'($urandom); din2 = 2'($urandom);
            cyc();
        end
        // saturate the error counter
        rst_n = 1'b1; en = 3'b010; clr = '0; din1 = 3'd7;
        repeat (300) cyc();
        en = '0;
`ifdef DECODER_SEQ_ERRCNT_EN
        check("errcnt_sat", 32'(ec1), 32'd255);
`endif
        cyc();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
